// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline advance/freeze/bubble/flush sequencer with memory-wait watchdog
// Optional: define PIPE_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic             mem_timeout
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_LU   = 2'b10;
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [1:0] state_q, state_d;
  logic       br_pend_q, br_pend_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       lu;

  assign lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Unreachable encoding 11 falls through the default arm and behaves as RUN.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_WAIT: state_d = mem_busy ? ST_WAIT : ST_RUN;
      ST_LU:   state_d = mem_busy ? ST_WAIT : ST_RUN;
      default: begin
        if (mem_busy)          state_d = ST_WAIT;
        else if (branch_taken) state_d = ST_RUN;
        else if (lu)           state_d = ST_LU;
        else                   state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst && !mem_busy) begin
      {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
      case (state_q)
        ST_WAIT: begin
          ifid_flush  = br_pend_q || branch_taken;
          idex_bubble = br_pend_q || branch_taken;
        end
        ST_LU: begin
          ifid_flush  = branch_taken;
          idex_bubble = branch_taken;
        end
        default: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  // Every frozen cycle counts toward the watchdog, including the one that enters WAIT.
  always_comb begin
    br_pend_d     = br_pend_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_busy) begin
      if (branch_taken) br_pend_d = 1'b1;
      wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 8'd1;
      if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
    end else if (state_q == ST_WAIT) begin
      br_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_pend_q     <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      br_pend_q     <= br_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl (MAX_WAIT=4)
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       ex_memread = 1'b0, mem_busy = 1'b0, branch_taken = 1'b0;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_hazard_ctrl #(.REG_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .state(state), .mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] LUW = 5'b00111;
  localparam logic [4:0] NON = 5'b00000;

  function automatic logic [9:0] e(input logic [4:0] we, input logic fl, input logic bu,
                                   input logic [1:0] st, input logic to);
    return {we, fl, bu, st, to};
  endfunction

  function automatic logic [9:0] obs();
    return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble, state, mem_timeout};
  endfunction

  task automatic check_pop();
    exp_t x;
    logic [9:0] o;
    x = q.pop_front();
    o = obs();
    checks++;
    assert (o === x.v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", x.tag, o, x.v);
    end
  endtask

  // Inputs are applied just after a rising edge, outputs sampled on the falling edge.
  task automatic step(input string tag, input logic busy, input logic br, input logic mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [9:0] ev);
    exp_t x;
    mem_busy = busy; branch_taken = br; ex_memread = mr;
    ex_rt = ert; id_rs = rs; id_rt = rt;
    x.tag = tag; x.v = ev;
    q.push_back(x);
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t x;
    #2;
    x.tag = "reset"; x.v = e(NON, 0, 0, 2'b00, 0);
    q.push_back(x);
    check_pop();
    @(posedge clk); #1;
    rst = 1'b0;

    step("first_cycle",  0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
    step("lu_rs_bubble", 0, 0, 1, 5'd5, 5'd5, 5'd1, e(LUW, 0, 1, 2'b00, 0));
    step("lu_state",     0, 0, 1, 5'd5, 5'd5, 5'd1, e(ALL, 0, 0, 2'b10, 0));
    step("lu_rt0_none",  0, 0, 1, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
    step("lu_rt_bubble", 0, 0, 1, 5'd7, 5'd2, 5'd7, e(LUW, 0, 1, 2'b00, 0));
    step("lu_rt_state",  0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b10, 0));
    step("br_over_lu",   0, 1, 1, 5'd5, 5'd5, 5'd0, e(ALL, 1, 1, 2'b00, 0));
    step("br_no_lu",     0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
    step("wait_f1",      1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b00, 0));
    step("wait_f2_br",   1, 1, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 0));
    step("wait_f3",      1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 0));
    step("wait_release", 0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 1, 1, 2'b01, 0));
    step("brpend_clear", 0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
`ifdef PIPE_CTRL_STALL_CNT_EN
    checks++;
    assert (stall_cnt === 16'd5) else begin
      errors++;
      $error("FAIL stall_cnt observed=%0d expected=5", stall_cnt);
    end
`endif

    step("wd_f1",        1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b00, 0));
    step("wd_f2",        1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 0));
    step("wd_f3",        1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 0));
    step("wd_f4",        1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 0));
    step("wd_f5_to",     1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 1));
    step("wd_f6_to",     1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 1));
    step("wd_release",   0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b01, 1));
    step("wd_sticky",    0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 1));

    step("rst_w1_br",    1, 1, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b00, 1));
    step("rst_w2",       1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b01, 1));
    // DUT is in WAIT with a pending branch; reset between edges with busy dropped.
    #2;
    mem_busy = 1'b0;
    rst = 1'b1;
    x.tag = "async_rst"; x.v = e(NON, 0, 0, 2'b00, 0);
    q.push_back(x);
    #1;
    check_pop();
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst",     0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
    step("post_rst_f1",  1, 0, 0, 5'd0, 5'd0, 5'd0, e(NON, 0, 0, 2'b00, 0));
    step("post_rst_rel", 0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b01, 0));

    step("lu_again",     0, 0, 1, 5'd9, 5'd9, 5'd9, e(LUW, 0, 1, 2'b00, 0));
    step("lu_br_flush",  0, 1, 1, 5'd9, 5'd9, 5'd9, e(ALL, 1, 1, 2'b10, 0));
    step("lu_br_run",    0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b00, 0));
    step("lu_busy_set",  0, 0, 1, 5'd3, 5'd3, 5'd0, e(LUW, 0, 1, 2'b00, 0));
    step("lu_busy",      1, 0, 1, 5'd3, 5'd3, 5'd0, e(NON, 0, 0, 2'b10, 0));
    step("lu_busy_rel",  0, 0, 0, 5'd0, 5'd0, 5'd0, e(ALL, 0, 0, 2'b01, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
